// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD frame sender.
package lcd_pkg;

   // Command type presented alongside each byte
   localparam logic [1:0] OPER_IDLE  = 2'd0;
   localparam logic [1:0] OPER_DATA  = 2'd1;
   localparam logic [1:0] OPER_INSTR = 2'd2;

   // HD44780-style instruction bytes
   localparam logic [7:0] SETUP      = 8'h38;
   localparam logic [7:0] DISP_ON    = 8'h0C;
   localparam logic [7:0] ENTRY_N    = 8'h06;
   localparam logic [7:0] CLEAR      = 8'h01;
   localparam logic [7:0] LINE1_ADDR = 8'h80;
   localparam logic [7:0] LINE2_ADDR = 8'hC0;

   // Character bytes
   localparam logic [7:0] DOUBLE_DOT = 8'h3A;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] BLANK      = 8'h20;

   typedef enum logic [2:0] {
      RST_HOLD, INIT, IDLE, LATCH, ADDR, CHAR, SEP, DONE
   } state_t;

   // Power-up instruction sequence, indexed 0..3
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return SETUP;
         2'd1:    return DISP_ON;
         2'd2:    return ENTRY_N;
         default: return CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd_char_encode.sv
// Maps one BCD nibble to the ASCII byte shown on the LCD; non-decimal codes blank the cell.
import lcd_pkg::*;

module lcd_char_encode (
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   // Decimal digits become '0'..'9', anything above 9 becomes a space
   always_comb begin
      if (nibble <= 4'd9) ascii = ASCII_ZERO + {4'h0, nibble};
      else                ascii = BLANK;
   end

endmodule

// File: rtl/lcd_frame_sender.sv
// Streams a snapshot of BCD digits to a character LCD as a command/data byte sequence.
import lcd_pkg::*;

module lcd_frame_sender #(
   parameter int                  N_DIGITS       = 8,
   parameter logic [N_DIGITS-1:0] SEP_MASK       = N_DIGITS'('h44),
   parameter int                  SPLIT_AT       = 4,
   parameter int                  AUTO_REFRESH   = 1,
   parameter int                  SKIP_UNCHANGED = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] dataIn,
   input  logic                  refresh,
   input  logic                  lcdReady,
   output logic [7:0]            dataOut,
   output logic [1:0]            OPER,
   output logic                  ENB,
   output logic                  RST,
   output logic                  frame_done,
   output logic                  busy
);

   localparam int             IW     = 5;
   localparam logic [IW-1:0]  N_I    = IW'(N_DIGITS);
   localparam logic [IW-1:0]  SPLIT_I = IW'(SPLIT_AT);
   localparam bit             HAS_L2 = (SPLIT_AT < N_DIGITS);

   state_t                  state_reg, state_next;
   logic [1:0]              init_idx_reg;
   logic [IW-1:0]           dig_idx_reg;
   logic                    home_sent_reg;
   logic [4*N_DIGITS-1:0]   snap_reg;
   logic [4*N_DIGITS-1:0]   last_reg;
   logic                    last_valid_reg;
   logic                    pending_reg;

   logic                    go;
   logic                    skip_frame;
   logic                    take_frame;
   logic [3:0]              cur_nib;
   logic [7:0]              cur_ascii;
   logic                    cmd_issue;
   logic [7:0]              cmd_byte;
   logic [1:0]              cmd_oper;

   // Which state handles digit position idx: line-2 address, separator, character, or end of frame
   function automatic state_t entry_state(input logic [IW-1:0] idx, input logic allow_l2);
      logic sep;
      sep = 1'b0;
      for (int i = 0; i < N_DIGITS; i++)
         if (idx == IW'(i)) sep = SEP_MASK[i];
      if (idx >= N_I)                               return DONE;
      else if (HAS_L2 && allow_l2 && idx == SPLIT_I) return ADDR;
      else if (sep)                                  return SEP;
      else                                           return CHAR;
   endfunction

   // A command may only go out when the driver is ready and the previous strobe has dropped
   assign go         = lcdReady && !ENB;
   assign skip_frame = (SKIP_UNCHANGED != 0) && last_valid_reg && (dataIn == last_reg);
   assign take_frame = (state_reg == IDLE) && (state_next == LATCH);

   // Select the digit currently being written from the frozen snapshot
   always_comb begin
      cur_nib = 4'h0;
      for (int i = 0; i < N_DIGITS; i++)
         if (dig_idx_reg == IW'(i)) cur_nib = snap_reg[4*i +: 4];
   end

   lcd_char_encode u_enc (
      .nibble (cur_nib),
      .ascii  (cur_ascii)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= RST_HOLD;
      else        state_reg <= state_next;
   end

   // Next-state logic; every transition waits on lcdReady except leaving the reset hold
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RST_HOLD: state_next = INIT;
         INIT:     if (go && init_idx_reg == 2'd3) state_next = IDLE;
         IDLE:     if (lcdReady && (AUTO_REFRESH != 0 || pending_reg || refresh)) state_next = LATCH;
         LATCH:    if (lcdReady) state_next = skip_frame ? DONE : ADDR;
         ADDR:     if (go) state_next = entry_state(dig_idx_reg, !home_sent_reg);
         SEP:      if (go) state_next = CHAR;
         CHAR:     if (go) state_next = entry_state(dig_idx_reg + IW'(1), 1'b1);
         DONE:     if (lcdReady) state_next = IDLE;
         default:  state_next = RST_HOLD;
      endcase
   end

   // Command selection for the current state
   always_comb begin
      cmd_issue = 1'b0;
      cmd_byte  = 8'h00;
      cmd_oper  = OPER_IDLE;
      case (state_reg)
         INIT: begin
            cmd_issue = go;
            cmd_byte  = init_cmd(init_idx_reg);
            cmd_oper  = OPER_INSTR;
         end
         ADDR: begin
            cmd_issue = go;
            cmd_byte  = home_sent_reg ? LINE2_ADDR : LINE1_ADDR;
            cmd_oper  = OPER_INSTR;
         end
         SEP: begin
            cmd_issue = go;
            cmd_byte  = DOUBLE_DOT;
            cmd_oper  = OPER_DATA;
         end
         CHAR: begin
            cmd_issue = go;
            cmd_byte  = cur_ascii;
            cmd_oper  = OPER_DATA;
         end
         default: ;
      endcase
   end

   // Output registers, frame pointers, snapshot and refresh bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dataOut        <= 8'h00;
         OPER           <= OPER_IDLE;
         ENB            <= 1'b0;
         RST            <= 1'b1;
         frame_done     <= 1'b0;
         busy           <= 1'b1;
         init_idx_reg   <= 2'd0;
         dig_idx_reg    <= '0;
         home_sent_reg  <= 1'b0;
         snap_reg       <= '0;
         last_reg       <= '0;
         last_valid_reg <= 1'b0;
         pending_reg    <= 1'b0;
      end else begin
         RST        <= 1'b0;
         ENB        <= cmd_issue;
         frame_done <= (state_reg == DONE) && lcdReady;
         busy       <= (state_next != IDLE);
         if (cmd_issue) begin
            dataOut <= cmd_byte;
            OPER    <= cmd_oper;
         end
         // A request consumed by the IDLE->LATCH hop is not remembered again
         pending_reg <= take_frame ? 1'b0 : (pending_reg | refresh);
         if (state_reg == INIT && cmd_issue) init_idx_reg <= init_idx_reg + 2'd1;
         if (state_reg == LATCH && lcdReady) begin
            snap_reg      <= dataIn;
            dig_idx_reg   <= '0;
            home_sent_reg <= 1'b0;
            if (!skip_frame) begin
               last_reg       <= dataIn;
               last_valid_reg <= 1'b1;
            end
         end
         if (state_reg == ADDR && cmd_issue) home_sent_reg <= 1'b1;
         if (state_reg == CHAR && cmd_issue) dig_idx_reg <= dig_idx_reg + IW'(1);
      end
   end

endmodule

// File: tb/tb_lcd_frame_sender.sv
// Scoreboard bench: expected {OPER,dataOut} words and frame_done markers are queued by the
// stimulus and popped by per-DUT monitors. dut0 uses defaults; dut1 is refresh-driven with skip.
module tb_lcd_frame_sender;

   typedef logic [9:0] frame_t [12];

   localparam logic [9:0] MARK = 10'h3FF;
   localparam frame_t INIT_SEQ_PAD = '{10'h238, 10'h20C, 10'h206, 10'h201,
                                      10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0};
   // 32'h5904_3012
   localparam frame_t FA = '{10'h280, 10'h132, 10'h131, 10'h13A, 10'h130, 10'h133,
                            10'h2C0, 10'h134, 10'h130, 10'h13A, 10'h139, 10'h135};
   // 32'h0000_0987
   localparam frame_t FB = '{10'h280, 10'h137, 10'h138, 10'h13A, 10'h139, 10'h130,
                            10'h2C0, 10'h130, 10'h130, 10'h13A, 10'h130, 10'h130};
   // 32'h1234_5678
   localparam frame_t FC = '{10'h280, 10'h138, 10'h137, 10'h13A, 10'h136, 10'h135,
                            10'h2C0, 10'h134, 10'h133, 10'h13A, 10'h132, 10'h131};
   // 32'hF000_00A9 (digits above 9 are blanks)
   localparam frame_t FD = '{10'h280, 10'h139, 10'h120, 10'h13A, 10'h130, 10'h130,
                            10'h2C0, 10'h130, 10'h130, 10'h13A, 10'h130, 10'h120};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0_n = 1'b0, rst1_n = 1'b0;
   logic [31:0] data0 = 32'h5904_3012, data1 = 32'h1234_5678;
   logic        refresh0 = 1'b0, refresh1 = 1'b0;
   logic        lcdReady0 = 1'b1, lcdReady1 = 1'b1;
   logic [7:0]  dataOut0, dataOut1;
   logic [1:0]  OPER0, OPER1;
   logic        ENB0, ENB1, RST0, RST1, frame_done0, frame_done1, busy0, busy1;

   logic [9:0]  q0[$];
   logic [9:0]  q1[$];
   int          checks = 0, errors = 0;
   int          cmd_cnt0 = 0, done_cnt0 = 0, cmd_cnt1 = 0, done_cnt1 = 0;
   bit          mon_en0 = 1'b0, mon_en1 = 1'b0, rand_en = 1'b0;
   logic        rdy_edge0 = 1'b1;
   logic        prev_enb0 = 1'b0, prev_enb1 = 1'b0;

   lcd_frame_sender dut0 (
      .clk (clk), .rst_n (rst0_n), .dataIn (data0), .refresh (refresh0),
      .lcdReady (lcdReady0), .dataOut (dataOut0), .OPER (OPER0), .ENB (ENB0),
      .RST (RST0), .frame_done (frame_done0), .busy (busy0)
   );

   lcd_frame_sender #(.AUTO_REFRESH (0), .SKIP_UNCHANGED (1)) dut1 (
      .clk (clk), .rst_n (rst1_n), .dataIn (data1), .refresh (refresh1),
      .lcdReady (lcdReady1), .dataOut (dataOut1), .OPER (OPER1), .ENB (ENB1),
      .RST (RST1), .frame_done (frame_done1), .busy (busy1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic push_word(input int which, input logic [9:0] w);
      if (which == 0) q0.push_back(w);
      else            q1.push_back(w);
   endtask

   task automatic push_init(input int which);
      for (int i = 0; i < 4; i++) push_word(which, INIT_SEQ_PAD[i]);
   endtask

   task automatic push_frame(input int which, input frame_t f);
      for (int i = 0; i < 12; i++) push_word(which, f[i]);
      push_word(which, MARK);
   endtask

   function automatic int get_cnt(input int which);
      case (which)
         0:       return cmd_cnt0;
         1:       return done_cnt0;
         2:       return cmd_cnt1;
         default: return done_cnt1;
      endcase
   endfunction

   // Bounded wait on a monitor counter; a timeout is reported as a failed comparison
   task automatic wait_cnt(input int which, input int target, input string name);
      int k;
      k = 0;
      while (get_cnt(which) < target && k < 3000) begin
         @(posedge clk);
         k++;
      end
      check(name, 32'(get_cnt(which) >= target), 32'd1);
   endtask

   task automatic check_reset0(input string tag);
      check({tag, "_dataOut"},    32'(dataOut0),    32'h00);
      check({tag, "_OPER"},       32'(OPER0),       32'd0);
      check({tag, "_ENB"},        32'(ENB0),        32'd0);
      check({tag, "_RST"},        32'(RST0),        32'd1);
      check({tag, "_frame_done"}, 32'(frame_done0), 32'd0);
      check({tag, "_busy"},       32'(busy0),       32'd1);
   endtask

   task automatic pulse_refresh1();
      @(posedge clk); #1 refresh1 = 1'b1;
      @(posedge clk); #1 refresh1 = 1'b0;
   endtask

   // lcdReady0 driver: random while rand_en, otherwise held high
   initial forever begin
      @(posedge clk);
      #1 lcdReady0 = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Value of lcdReady0 that the DUT actually saw at the last rising edge
   always @(posedge clk) rdy_edge0 <= lcdReady0;

   // dut0 monitor
   always @(negedge clk) begin
      if (rst0_n && mon_en0) begin
         if (ENB0) begin
            check("enb_gap0", 32'(prev_enb0), 32'd0);
            check("rdy_at_issue0", 32'(rdy_edge0), 32'd1);
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cmd0: got %h expected none", {OPER0, dataOut0});
            end else begin
               check($sformatf("cmd0_%0d", cmd_cnt0), 32'({OPER0, dataOut0}), 32'(q0.pop_front()));
            end
            cmd_cnt0++;
         end
         if (frame_done0) begin
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done0: got frame_done expected none");
            end else begin
               check($sformatf("done0_%0d", done_cnt0), 32'(MARK), 32'(q0.pop_front()));
            end
            done_cnt0++;
         end
      end
      prev_enb0 = ENB0;
   end

   // dut1 monitor
   always @(negedge clk) begin
      if (rst1_n && mon_en1) begin
         if (ENB1) begin
            check("enb_gap1", 32'(prev_enb1), 32'd0);
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cmd1: got %h expected none", {OPER1, dataOut1});
            end else begin
               check($sformatf("cmd1_%0d", cmd_cnt1), 32'({OPER1, dataOut1}), 32'(q1.pop_front()));
            end
            cmd_cnt1++;
         end
         if (frame_done1) begin
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done1: got frame_done expected none");
            end else begin
               check($sformatf("done1_%0d", done_cnt1), 32'(MARK), 32'(q1.pop_front()));
            end
            done_cnt1++;
         end
      end
      prev_enb1 = ENB1;
   end

   initial begin
      // ---------------- dut0: defaults, auto refresh ----------------
      push_init(0);
      push_frame(0, FA);
      push_frame(0, FA);
      push_frame(0, FA);
      repeat (3) @(posedge clk);
      #1 check_reset0("rst0");
      mon_en0 = 1'b1;
      rst0_n  = 1'b1;
      #1 check("rst_hold_high0", 32'(RST0), 32'd1);
      @(posedge clk); #1 check("rst_hold_drop0", 32'(RST0), 32'd0);

      wait_cnt(1, 1, "frame1_done0");
      rand_en = 1'b1;
      wait_cnt(1, 2, "frame2_done0_random_ready");
      rand_en = 1'b0;

      // Change input three commands into frame 3: frame 3 keeps the old value
      wait_cnt(0, 31, "frame3_started0");
      #1 data0 = 32'h0000_0987;
      push_frame(0, FB);
      push_word(0, 10'h280);
      push_word(0, 10'h137);
      push_word(0, 10'h138);
      push_word(0, 10'h13A);

      // Reset while frame 5 is writing its third character
      wait_cnt(0, 56, "frame5_third_char0");
      #1 rst0_n = 1'b0;
      #1 check_reset0("midrst0");
      check("midrst_queue_drained0", 32'(q0.size()), 32'd0);
      push_init(0);
      push_frame(0, FB);
      repeat (2) @(posedge clk);
      #1 rst0_n = 1'b1;
      wait_cnt(1, 5, "frame_after_reset0");
      mon_en0 = 1'b0;
      check("cmd_total0", 32'(cmd_cnt0), 32'd72);

      // ---------------- dut1: refresh-driven, skip unchanged ----------------
      check("rst1_busy", 32'(busy1), 32'd1);
      check("rst1_RST", 32'(RST1), 32'd1);
      push_init(1);
      mon_en1 = 1'b1;
      @(posedge clk); #1 rst1_n = 1'b1;
      wait_cnt(2, 4, "init_done1");
      repeat (3) @(posedge clk);
      #1 check("idle_busy1", 32'(busy1), 32'd0);

      push_frame(1, FC);
      pulse_refresh1();
      wait_cnt(2, 6, "frame1_started1");
      // Three requests mid-frame merge into one extra frame, which is skipped
      push_word(1, MARK);
      repeat (3) begin
         pulse_refresh1();
         repeat (2) @(posedge clk);
      end
      wait_cnt(3, 2, "skip_frame_done1");
      repeat (3) @(posedge clk);
      #1 check("idle_busy_after_skip1", 32'(busy1), 32'd0);

      data1 = 32'hF000_00A9;
      push_frame(1, FD);
      pulse_refresh1();
      wait_cnt(3, 3, "changed_frame_done1");
      repeat (60) @(posedge clk);
      check("queue_empty1", 32'(q1.size()), 32'd0);
      check("done_total1", 32'(done_cnt1), 32'd3);
      check("cmd_total1", 32'(cmd_cnt1), 32'd28);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
